sel_ctrl: RTL and testbench
===========================

SEL_CTRL -- requirements
Module: sel_ctrl

Interface
REQ-001 Parameter: DB_CYCLES, 16, consecutive stable synchronized cycles needed to accept a button level change (legal range 2..2^20).
REQ-002 Parameter: SCAN_DIV, 8, clock cycles per automatic select toggle (legal range 2..2^24).
REQ-003 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: btn  input  1  raw, asynchronous, bouncy push-button.
REQ-006 Port: mode  input  1  raw slide switch: 0 = manual toggle, 1 = auto scan.
REQ-007 Port: s  output  1  registered select; drives the select input of the team's 2:1 mux (mux_21).
REQ-008 Port: s_toggle  output  1  one-cycle pulse in the first cycle that s shows a new value.
REQ-009 Port: press  output  1  one-cycle pulse per accepted (debounced) button press.
REQ-010 Port: btn_db  output  1  debounced button level.

Function
REQ-011 btn and mode SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce FSM states SHALL be IDLE, ARM_PRESS, HELD and ARM_RELEASE, with one down/up counter of width clog2(DB_CYCLES)+1.
REQ-013 IDLE->ARM_PRESS on sync_btn=1 (counter cleared).
REQ-014 ARM_PRESS->IDLE on sync_btn=0.
REQ-015 ARM_PRESS->HELD after DB_CYCLES consecutive cycles of sync_btn=1.
REQ-016 HELD->ARM_RELEASE on sync_btn=0.
REQ-017 ARM_RELEASE->HELD on sync_btn=1.
REQ-018 ARM_RELEASE->IDLE after DB_CYCLES consecutive cycles of sync_btn=0.
REQ-019 btn_db SHALL be 1 in HELD and ARM_RELEASE, and 0 in IDLE and ARM_PRESS.
REQ-020 press SHALL pulse for exactly one cycle on the ARM_PRESS->HELD transition.
REQ-021 Latency from the first rising edge sampling btn=1 (held stable) to press=1 SHALL be DB_CYCLES+2 cycles.
REQ-022 A release bounce (ARM_RELEASE->HELD) SHALL NOT generate press.
REQ-023 Manual mode (sync_mode=0): s SHALL invert on the edge following a press pulse, i.e. s changes 1 cycle after press.
REQ-024 Auto mode (sync_mode=1): a prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; s SHALL invert on each wrap, giving an s period of 2*SCAN_DIV cycles.
REQ-025 In auto mode, press SHALL still pulse, but SHALL NOT affect s or the prescaler.
REQ-026 On any change of sync_mode, the prescaler SHALL clear to 0 and s SHALL hold its current value.
REQ-027 If a press pulse and a mode change occur in the same cycle, the new sync_mode SHALL govern the action.
REQ-028 s SHALL never change more than once per cycle.
REQ-029 s_toggle SHALL be high if and only if s differs from its value in the previous cycle.

Reset
REQ-030 While reset=1, independent of clk: s=0, s_toggle=0, press=0, btn_db=0, FSM=IDLE, debounce counter=0, prescaler=0, all synchronizer flops=0.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count; after release, a full DB_CYCLES+2 qualification SHALL be required.
REQ-032 The first cycle after reset release SHALL NOT produce s_toggle or press.

Structure
REQ-033 FSM state encodings (2-bit) and default parameter values SHALL live in the shared package dp2_pkg.
REQ-034 Synchronizer, FSM and counter SHALL form sub-module btn_debounce (ports clk, reset, btn, btn_db, press).
REQ-035 sel_ctrl SHALL instantiate btn_debounce and hold the mode synchronizer, prescaler and s logic.

Verification (DB_CYCLES=4, SCAN_DIV=3)
REQ-036 Manual clean press: mode=0, btn=1 held 12 cycles -> press high in cycle 6 only; s 0->1 in cycle 7; s_toggle high in cycle 7; btn_db=1.
REQ-037 Press bounce: btn pattern 1,1,0,1,1,0 then 0 -> press never asserts; s stays 0; btn_db stays 0.
REQ-038 Auto scan: mode=1 from reset -> after 2-cycle sync, s toggles every 3 cycles (period 6); a clean press mid-scan -> press pulses, s sequence unchanged.
REQ-039 Async reset: assert reset mid-ARM_PRESS with s=1 -> s=0 before the next clk edge; after release with btn still high, press arrives 6 cycles later, not earlier.
REQ-040 Mode switch: auto -> manual with s=1 -> s stays 1 with no further auto toggles; next clean press -> s=0 with one s_toggle pulse.

Source files
------------

// File: rtl/dp2_pkg.sv
// dp2_pkg: shared debounce state encoding and default timing parameters
package dp2_pkg;
  localparam int unsigned DB_CYCLES_DEF = 16;
  localparam int unsigned SCAN_DIV_DEF = 8;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } db_state_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a bouncy button and accepts level changes after DB_CYCLES stable cycles
module btn_debounce
  import dp2_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic press_q, press_d;
  // two-flop synchronizer on the raw button
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync1_q, sync2_q} <= 2'b00;
    else {sync1_q, sync2_q} <= {btn, sync1_q};
  // debounce state, shared counter and registered press pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  // counts up while arming a press, down while arming a release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE:
        if (sync2_q) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      ARM_PRESS:
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      HELD:
        if (!sync2_q) begin
          state_d = ARM_RELEASE;
          cnt_d   = LAST;
        end
      ARM_RELEASE:
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  assign btn_db = (state_q == HELD) || (state_q == ARM_RELEASE);
  assign press  = press_q;
endmodule

// File: rtl/sel_ctrl.sv
// sel_ctrl: 2:1 mux select driven by debounced button presses or an automatic scan
module sel_ctrl
  import dp2_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic mode,
  output logic s,
  output logic s_toggle,
  output logic press,
  output logic btn_db
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
  logic mode1_q, mode2_q, mode_prev_q;
  logic [PW-1:0] psc_q, psc_d;
  logic s_q, s_d, s_toggle_q, s_toggle_d;
  logic mode_chg, wrap;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .btn_db(btn_db),
    .press (press)
  );
  assign mode_chg = mode2_q ^ mode_prev_q;
  assign wrap     = psc_q == PLAST;
  // the synchronized mode chooses the toggle source; a mode change restarts the scan and holds s
  always_comb begin
    psc_d      = (mode2_q && !mode_chg && !wrap) ? psc_q + 1'b1 : '0;
    s_d        = s_q ^ (mode2_q ? (!mode_chg && wrap) : press);
    s_toggle_d = s_d ^ s_q;
  end
  // mode synchronizer, change detector, prescaler and select register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {mode1_q, mode2_q, mode_prev_q} <= 3'b000;
      psc_q      <= '0;
      s_q        <= 1'b0;
      s_toggle_q <= 1'b0;
    end else begin
      {mode1_q, mode2_q, mode_prev_q} <= {mode, mode1_q, mode2_q};
      psc_q      <= psc_d;
      s_q        <= s_d;
      s_toggle_q <= s_toggle_d;
    end
  assign s        = s_q;
  assign s_toggle = s_toggle_q;
endmodule

// File: tb/tb_sel_ctrl.sv
// tb_sel_ctrl: table vectors, corner sequences and random stimulus against a behavioural model
module tb_sel_ctrl;
  localparam int DB = 4;
  localparam int SD = 3;
  logic clk = 1'b0, reset = 1'b1, btn = 1'b0, mode = 1'b0;
  logic s, s_toggle, press, btn_db;
  int checks = 0, errors = 0;
  typedef struct {bit btn; bit mode; bit press; bit s; bit tog; bit db;} vec_t;
  vec_t tbl[24];
  bit bq[2], mq[2];
  bit m_prev, m_lvl, m_press, m_s, m_tog;
  int run, elapsed;

  always #5 clk = ~clk;

  sel_ctrl #(.DB_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .btn(btn), .mode(mode),
    .s(s), .s_toggle(s_toggle), .press(press), .btn_db(btn_db)
  );

  function automatic void model_reset();
    bq = '{0, 0}; mq = '{0, 0};
    m_prev = 0; m_lvl = 0; m_press = 0; m_s = 0; m_tog = 0;
    run = 0; elapsed = 0;
  endfunction

  // a level is accepted once the synchronized button differs from it on DB+1 consecutive edges
  function automatic void model_edge(bit b, bit md);
    bit sb, sm, chg, tog, np;
    sb = bq[1]; bq[1] = bq[0]; bq[0] = b;
    sm = mq[1]; mq[1] = mq[0]; mq[0] = md;
    np = 0;
    if (sb != m_lvl) begin
      run++;
      if (run == DB + 1) begin m_lvl = !m_lvl; run = 0; np = m_lvl; end
    end else run = 0;
    chg = sm != m_prev; m_prev = sm;
    tog = 0;
    if (!sm) begin tog = m_press; elapsed = 0; end
    else if (chg) elapsed = 0;
    else begin elapsed++; tog = (elapsed % SD) == 0; end
    m_s ^= tog; m_tog = tog; m_press = np;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(btn, mode);
    @(negedge clk);
    check("model_s", s, m_s);
    check("model_s_toggle", s_toggle, m_tog);
    check("model_press", press, m_press);
    check("model_btn_db", btn_db, m_lvl);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_s", s, 0);
    check("reset_s_toggle", s_toggle, 0);
    check("reset_press", press, 0);
    check("reset_btn_db", btn_db, 0);
    reset = 1'b0;
  endtask

  task automatic hold(bit b, int n);
    btn = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [11:0] pat;
    int cnt, first;
    bit found;
    pat = 12'b0000_0001_1011;
    for (int i = 0; i < 12; i++) tbl[i] = '{1, 0, i == 6, i >= 7, i == 7, i >= 6};
    for (int i = 0; i < 12; i++) tbl[12 + i] = '{pat[i], 0, 0, 0, 0, 0};
    model_reset();
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || i == 12) begin btn = 1'b0; do_reset(); end
      btn = tbl[i].btn;
      mode = tbl[i].mode;
      tick();
      check($sformatf("vec%0d_press", i), press, tbl[i].press);
      check($sformatf("vec%0d_s", i), s, tbl[i].s);
      check($sformatf("vec%0d_s_toggle", i), s_toggle, tbl[i].tog);
      check($sformatf("vec%0d_btn_db", i), btn_db, tbl[i].db);
    end

    btn = 1'b0; mode = 1'b1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      check($sformatf("auto_s%0d", i), s, (i >= 5) ? (((i - 5) / 3) % 2 == 0) : 0);
    end
    cnt = 0;
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn = 1'b0;
      tick();
      cnt += press;
    end
    check("auto_press_count", cnt, 1);

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s && s_toggle;
    end
    check("auto_reach_s1", found, 1);
    mode = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin tick(); cnt += s_toggle; end
    check("manual_no_auto_toggle", cnt, 0);
    check("manual_s_held", s, 1);
    cnt = 0;
    btn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) btn = 1'b0;
      tick();
      cnt += s_toggle;
    end
    check("manual_toggle_count", cnt, 1);
    check("manual_s_after_press", s, 0);

    hold(1, 12);
    hold(0, 12);
    check("pre_reset_s", s, 1);
    hold(1, 4);
    #2 reset = 1'b1;
    #1;
    check("async_s", s, 0);
    check("async_btn_db", btn_db, 0);
    check("async_press", press, 0);
    check("async_s_toggle", s_toggle, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (press && first < 0) first = i;
    end
    check("post_reset_press_latency", first, 6);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
